// File: rtl/div_unit.sv
// div_unit: sequential signed restoring divider, one quotient bit per clock.
// z = {remainder, quotient}, packed for direct HI/LO loading.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
// Optional build macro: DIV_EARLY_EXIT_EN (skip iterations when |Q| < |b|).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; operands are latched on the accepting edge
//   SETUP  | record signs, form magnitudes, flag divide-by-zero
//   ITER   | one shift/trial-subtract step per cycle, WIDTH cycles
//   FIXUP  | apply signs, write z, pulse done, drop busy
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] z,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ITER,
    S_FIXUP
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] q_lat;
  logic [WIDTH-1:0] b_lat;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   mag_b;
  logic             sign_q;
  logic             sign_r;
  logic             dz;
  logic [CW-1:0]    count;

  // |Q| fits unsigned in WIDTH bits even for -2^(WIDTH-1); |b| keeps an extra bit
  // so the trial subtraction below can be done without any sign handling.
  logic [WIDTH-1:0] mag_q_c;
  logic [WIDTH:0]   mag_b_c;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] quo_f;
  logic [WIDTH-1:0] rem_f;

  assign mag_q_c = q_lat[WIDTH-1] ? -q_lat : q_lat;
  assign mag_b_c = b_lat[WIDTH-1] ? -{1'b1, b_lat} : {1'b0, b_lat};
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, mag_b};
  assign quo_f   = sign_q ? -quo : quo;
  assign rem_f   = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

`ifdef DIV_EARLY_EXIT_EN
  logic early_exit;
  assign early_exit = (b_lat != '0) && ({1'b0, mag_q_c} < mag_b_c);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SETUP;
      S_SETUP: begin
        state_nxt = S_ITER;
`ifdef DIV_EARLY_EXIT_EN
        if (early_exit) state_nxt = S_FIXUP;
`endif
      end
      S_ITER:  if (count == LAST) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, stepped by the current state.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_lat       <= '0;
      b_lat       <= '0;
      quo         <= '0;
      rem         <= '0;
      mag_b       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      count       <= '0;
      z           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            q_lat <= Q;
            b_lat <= b;
            busy  <= 1'b1;
          end
        end
        S_SETUP: begin
          sign_q <= q_lat[WIDTH-1] ^ b_lat[WIDTH-1];
          sign_r <= q_lat[WIDTH-1];
          dz     <= (b_lat == '0);
          mag_b  <= mag_b_c;
          rem    <= '0;
          quo    <= mag_q_c;
          count  <= '0;
`ifdef DIV_EARLY_EXIT_EN
          if (early_exit) begin
            rem <= {1'b0, mag_q_c};
            quo <= '0;
          end
`endif
        end
        S_ITER: begin
          if (!diff[WIDTH+1]) begin
            rem <= diff[WIDTH:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count + CW'(1);
        end
        S_FIXUP: begin
          // A zero divisor still runs the full sequence; its result is fixed.
          if (dz) z <= {q_lat, {WIDTH{1'b1}}};
          else    z <= {rem_f, quo_f};
          div_by_zero <= dz;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit: directed vectors, expected results queued at issue
// time and checked by a separate monitor whenever done pulses.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] Q;
  logic [31:0] b;
  logic [63:0] z;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .Q           (Q),
    .b           (b),
    .z           (z),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] z;
    logic        dz;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done_d = 1'b0;
  exp_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse consumes exactly one queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        cur = sb.pop_front();
        check({cur.name, "_z"}, z, cur.z);
        check({cur.name, "_dz"}, {63'd0, div_by_zero}, {63'd0, cur.dz});
        check({cur.name, "_latency"}, 64'(cyc), 64'(cur.due));
        check({cur.name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      end
      if (done_d) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_width: done high on consecutive cycles (cycle %0d)", cyc);
      end
    end
    done_d <= done;
  end

  // Called at a negedge: drive start for one edge, then scramble the operand
  // inputs so a design that does not latch them produces wrong results.
  task automatic issue(input string nm, input logic [31:0] q, input logic [31:0] d,
                       input logic [63:0] ez, input logic edz, input bit early);
    exp_t e;
    int   lat;
    lat = 34;
`ifdef DIV_EARLY_EXIT_EN
    if (early) lat = 2;
`else
    if (early) lat = 34;
`endif
    Q = q;
    b = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    Q = 32'hDEAD_BEEF;
    b = 32'h1234_5679;
    check({nm, "_busy_after_accept"}, {63'd0, busy}, 64'd1);
    e.z = ez;
    e.dz = edz;
    e.due = cyc + lat;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: still busy, %0d results outstanding", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_done_timeout: done=0 required 1", nm);
    end
  endtask

  task automatic run(input string nm, input logic [31:0] q, input logic [31:0] d,
                     input logic [63:0] ez, input logic edz, input bit early);
    issue(nm, q, d, ez, edz, early);
    wait_idle(nm);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    clr = 1'b1;
    start = 1'b0;
    Q = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset_z", z, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_dz", {63'd0, div_by_zero}, 64'd0);
    clr = 1'b0;
    @(negedge clk);

    //   name        Q              b              expected {rem, quo}                  dz    early
    run("p100_p7",   32'd100,       32'd7,         {32'd2,          32'd14},            1'b0, 1'b0);
    run("m100_p7",   32'hFFFFFF9C,  32'd7,         {32'hFFFFFFFE,   32'hFFFFFFF2},      1'b0, 1'b0);
    run("p100_m7",   32'd100,       32'hFFFFFFF9,  {32'd2,          32'hFFFFFFF2},      1'b0, 1'b0);
    run("m100_m7",   32'hFFFFFF9C,  32'hFFFFFFF9,  {32'hFFFFFFFE,   32'd14},            1'b0, 1'b0);
    run("min_m1",    32'h80000000,  32'hFFFFFFFF,  {32'h0,          32'h80000000},      1'b0, 1'b0);
    run("min_p2",    32'h80000000,  32'd2,         {32'h0,          32'hC0000000},      1'b0, 1'b0);
    run("p5_zero",   32'd5,         32'd0,         {32'h5,          32'hFFFFFFFF},      1'b1, 1'b0);
    run("p9_p2",     32'd9,         32'd2,         {32'd1,          32'd4},             1'b0, 1'b0);
    run("p3_p10",    32'd3,         32'd10,        {32'd3,          32'd0},             1'b0, 1'b1);
    run("m3_p10",    32'hFFFFFFFD,  32'd10,        {32'hFFFFFFFD,   32'd0},             1'b0, 1'b1);
    run("max_p1",    32'h7FFFFFFF,  32'd1,         {32'd0,          32'h7FFFFFFF},      1'b0, 1'b0);
    run("min_min",   32'h80000000,  32'h80000000,  {32'd0,          32'd1},             1'b0, 1'b0);
    run("m7_zero",   32'hFFFFFFF9,  32'd0,         {32'hFFFFFFF9,   32'hFFFFFFFF},      1'b1, 1'b0);
    run("zero_p5",   32'd0,         32'd5,         {32'd0,          32'd0},             1'b0, 1'b1);
    run("p1_min",    32'd1,         32'h80000000,  {32'd1,          32'd0},             1'b0, 1'b1);
    run("max_min",   32'h7FFFFFFF,  32'h80000000,  {32'h7FFFFFFF,   32'd0},             1'b0, 1'b1);
    run("min_p3",    32'h80000000,  32'd3,         {32'hFFFFFFFE,   32'hD5555556},      1'b0, 1'b0);

    // start while busy is ignored and does not disturb the running divide
    issue("busy_start", 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    Q = 32'd1;
    b = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start");
    repeat (40) @(negedge clk);

    // start presented in the done cycle is accepted back-to-back
    issue("b2b_first", 32'd50, 32'd6, {32'd2, 32'd8}, 1'b0, 1'b0);
    wait_done("b2b_first");
    issue("b2b_second", 32'hFFFFFFCE, 32'd6, {32'hFFFFFFFE, 32'hFFFFFFF8}, 1'b0, 1'b0);
    wait_idle("b2b_second");

    // start sampled on the edge leaving FIXUP must be ignored
    @(negedge clk);
    issue("fixup_start", 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b0);
    acc = cyc - 1;
    while (cyc < acc + 34) @(negedge clk);
    Q = 32'd1;
    b = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("fixup_start_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    wait_idle("fixup_start");

    // clr mid-operation aborts without a done pulse, then a new divide runs
    issue("abort", 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b0);
    acc = cyc;
    while (cyc < acc + 9) @(negedge clk);
    sb.delete();
    clr = 1'b1;
    @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_z", z, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    clr = 1'b0;
    @(negedge clk);
    run("after_abort", 32'd9, 32'd2, {32'd1, 32'd4}, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Sequential signed integer divider; the inverse operation to the combinational Booth multiplier in the ALU.
- Computes the quotient and remainder of a 32-bit signed dividend Q divided by a 32-bit signed divisor b.
- Uses restoring division on magnitudes, one quotient bit per clock, with a start/busy/done handshake.
- Result is packed like the multiplier product, for direct HI/LO loading: z[63:32] = remainder (HI), z[31:0] = quotient (LO).

Parameters:
- WIDTH, 32, operand width. Quotient and remainder are each WIDTH bits; z is 2*WIDTH. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- clr  input  1  synchronous active-high reset
- start  input  1  operation request; sampled only in IDLE
- Q  input  WIDTH  signed dividend; captured on the accepting edge
- b  input  WIDTH  signed divisor; captured on the accepting edge
- z  output  2*WIDTH  {remainder, quotient}; registered
- busy  output  1  high from the accepting edge until done is asserted
- done  output  1  one-cycle pulse when z is valid
- div_by_zero  output  1  registered flag, updated together with done

Behaviour:
- Reset: clock is clk; reset is synchronous, active-high, named clr. While clr is high at an edge: state = IDLE, z = 0, busy = 0, done = 0, div_by_zero = 0, internal counters = 0.
  - clr has priority over every other input, including mid-operation.
  - An aborted operation never raises done.
- States: IDLE -> SETUP -> ITER -> FIXUP -> IDLE.
- IDLE:
  - If start = 1: latch Q and b, set busy = 1, go to SETUP.
  - Later changes to Q or b are ignored until the next accept.
- SETUP (1 cycle):
  - Record sign_q = Q[WIDTH-1] XOR b[WIDTH-1] and sign_r = Q[WIDTH-1].
  - Form magnitudes |Q| and |b| in WIDTH+1 bits, so that -2^(WIDTH-1) is representable.
  - Record dz = (b == 0).
  - Clear the partial remainder; load the quotient register with |Q|; count = 0.
  - Go to ITER.
- ITER (WIDTH cycles), each cycle:
  - Shift {remainder, quotient} left by 1.
  - Trial subtract |b| from the remainder.
  - If the result is non-negative: keep it and set quotient LSB = 1. Otherwise restore and set LSB = 0.
  - count increments; leave ITER when count == WIDTH-1 is processed.
- FIXUP (1 cycle):
  - Negate the quotient if sign_q; negate the remainder if sign_r.
  - Write z, pulse done = 1, set busy = 0, set div_by_zero = dz. Next state IDLE.
- Latency: done is high in the cycle following the 34th rising edge after the accepting edge (SETUP 1 + ITER 32 + FIXUP 1). Latency is fixed, independent of data.
- Arithmetic:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Invariant: Q = q*b + r, with |r| < |b|.
- Overflow: -2^31 / -1 gives quotient 0x80000000 (wraps) and remainder 0. No flag is raised.
- Divide by zero:
  - Full latency is kept.
  - z = {Q_latched, 32'hFFFFFFFF}; div_by_zero = 1.
- z holds its value until the next FIXUP or clr. done is high for exactly one cycle.
- start while busy: ignored, no queueing.
- start in the same cycle done is high: accepted, because the state is already IDLE at that edge if the FSM has returned.
  - Required: start sampled on the edge that leaves FIXUP is ignored.
  - Start is accepted only when state == IDLE before the edge.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - In SETUP, if dz = 0 and |Q| < |b|: skip ITER and go directly to FIXUP with quotient 0 and remainder Q_latched.
  - done is high 2 edges after the accepting edge.
- Undefined:
  - Always the fixed 34-cycle latency.
  - Results are identical in both builds.

Test Plan:
- Q=100, b=7, start pulse -> busy 1 for 34 cycles; done pulses once; z = {32'd2, 32'd14}; div_by_zero = 0.
- Q=-100 (0xFFFFFF9C), b=7 -> z = {32'hFFFFFFFE, 32'hFFFFFFF2}. Also Q=100, b=-7 -> z = {32'd2, 32'hFFFFFFF2}.
- Q=0x80000000, b=0xFFFFFFFF -> z = {32'h0, 32'h80000000}, div_by_zero = 0. Also Q=0x80000000, b=2 -> quotient 0xC0000000, remainder 0.
- Q=5, b=0 -> after 34 cycles z = {32'h5, 32'hFFFFFFFF}, div_by_zero = 1.
- Start Q=100, b=7; change Q/b and pulse start at cycle 5; assert clr at cycle 10 -> busy = 0 and z = 0 after that edge, no done pulse. A new start at cycle 12 with 9/2 -> z = {1, 4} at cycle 12+34.
- Q=3, b=10 -> z = {32'd3, 32'd0}. done arrives after 2 edges with DIV_EARLY_EXIT_EN defined, after 34 edges without it.
